hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
Pipeline stall/flush controller that acts on the hazards the forwarding path cannot resolve. It sits beside the ID stage. It keeps its own shadow scoreboard of in-flight destination registers for ID/EX, EX/MEM and MEM/WB, and detects load-use hazards. After a branch or jump leaves ID, it holds fetch and squashes IF/ID until the control instruction drains. It drives the hold, flush and bubble controls for the PC, IF/ID and ID/EX registers, and keeps a saturating stall-cycle counter.

Parameters:
CTRL_DRAIN, 3, cycles fetch stays held after a branch or jump advances out of ID.
CNT_W, 16, width of the stall performance counter.

Ports:
clk  input  1  clock; everything updates on its rising edge.
rst  input  1  synchronous, active-high reset.
valid_ID  input  1  ID holds a real (non-nop) instruction.
r1Num_ID  input  3  first source register of the ID instruction.
r2Num_ID  input  3  second source register of the ID instruction.
useR1_ID  input  1  the ID instruction reads r1Num_ID.
useR2_ID  input  1  the ID instruction reads r2Num_ID.
regWriteNum_ID  input  3  destination register of the ID instruction.
regWriteEnable_ID  input  1  the ID instruction writes a register.
memRead_ID  input  1  the ID instruction is a load.
ctrl_ID  input  1  the ID instruction is a branch or jump (J or PCCtr==01).
memStall  input  1  data memory busy; freezes the whole pipeline.
pcStall  output  1  hold the PC.
ifidStall  output  1  hold IF/ID.
ifidFlush  output  1  load a nop into IF/ID.
idexBubble  output  1  load a nop into ID/EX.
pipeFreeze  output  1  freeze all pipeline registers (equals memStall).
ctrlBusy  output  1  state is CTRL.
stallCount  output  CNT_W  saturating count of cycles with pcStall=1.

Behaviour:
- Scoreboard: slots EX, MEM, WB; each slot holds {v, dst[2:0], wen, ld}. Reset value of every slot: v=0.
- Advance rule when memStall=0:
  - WB<=MEM, MEM<=EX.
  - EX<=ID fields if valid_ID & ~luHaz; otherwise EX<=bubble (v=0).
  - ID fields are not entered while state=CTRL, because ifidFlush makes ID a nop.
- When memStall=1, all slots, the state, the counter and stallCount hold.
- luHaz (combinational) = valid_ID & EX.v & EX.wen & EX.ld & ((useR1_ID & r1Num_ID==EX.dst) | (useR2_ID & r2Num_ID==EX.dst)).
- Register 0 is an ordinary register here; there is no r0 exemption.
- Only load-use stalls. EX/MEM and MEM/WB dependencies are covered by forwarding. The register file bypasses write-to-read in the same cycle.
- FSM states: IDLE, CTRL. Reset state is IDLE, with cnt=0.
- IDLE -> CTRL when memStall=0 & valid_ID & ctrl_ID & ~luHaz. cnt loads CTRL_DRAIN.
- CTRL: each cycle with memStall=0, cnt decrements. CTRL -> IDLE on the edge where cnt==1.
- A branch that has luHaz stays in ID; CTRL is entered on the first cycle luHaz clears.
- Outputs are combinational (Mealy). Priority order: memStall, then luHaz, then CTRL/ctrl.
  - pipeFreeze = memStall.
  - luHaz & ~memStall: pcStall=1, ifidStall=1, idexBubble=1, ifidFlush=0.
  - (state==CTRL, or the IDLE->CTRL transition cycle) & ~memStall & ~luHaz: pcStall=1, ifidFlush=1, ifidStall=0, idexBubble=0.
  - Otherwise all outputs are 0.
- PC redirect writes from the branch unit bypass pcStall. That is the PC block's responsibility.
- stallCount increments on each edge where pcStall=1 and memStall=0. It saturates at all-ones and never wraps.
- During reset, every output is driven 0, except pipeFreeze, which equals memStall (combinational).
- Reset mid-CTRL or mid-stall aborts to IDLE, clears the slots, and zeroes stallCount on that edge.

Test Plan:
- Load r3 in ID, next ID instruction reads r3 via useR1 -> exactly 1 cycle of pcStall=ifidStall=idexBubble=1, then all 0 with the consumer issued; stallCount=1.
- Load r3, then ALU, then reader of r3 (distance 2) -> no stall; ALU writer to r3 followed immediately by a reader -> no stall.
- Jump in ID at cycle t -> pcStall=ifidFlush=1 for cycles t..t+3 (CTRL_DRAIN=3 plus the transition cycle); ctrlBusy=1 for t+1..t+3; IDLE at t+4.
- Branch reading r5 right after a load to r5 -> 1 load-use stall cycle, then 4 flush cycles; stallCount=5.
- memStall=1 for 2 cycles in the middle of CTRL (cnt=2) -> pipeFreeze=1, cnt and stallCount hold, pcStall=0 and ifidFlush=0 during the freeze; CTRL resumes afterwards and ends 2 active cycles later.
- Preload stallCount to 0xFFFE through repeated stalls -> it saturates at 0xFFFF; rst asserted during CTRL -> ctrlBusy=0 and stallCount=0 on the next edge.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller beside ID: load-use detection from a shadow scoreboard,
// fetch hold and IF/ID squash while a branch/jump drains, saturating stall counter.
module hazard_stall_ctrl #(
  parameter int unsigned CTRL_DRAIN = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_ID,
  input  logic [2:0]       r1Num_ID,
  input  logic [2:0]       r2Num_ID,
  input  logic             useR1_ID,
  input  logic             useR2_ID,
  input  logic [2:0]       regWriteNum_ID,
  input  logic             regWriteEnable_ID,
  input  logic             memRead_ID,
  input  logic             ctrl_ID,
  input  logic             memStall,
  output logic             pcStall,
  output logic             ifidStall,
  output logic             ifidFlush,
  output logic             idexBubble,
  output logic             pipeFreeze,
  output logic             ctrlBusy,
  output logic [CNT_W-1:0] stallCount
);

  localparam int unsigned DRAIN_W = (CTRL_DRAIN < 2) ? 1 : $clog2(CTRL_DRAIN + 1);

  typedef struct packed {
    logic       v;
    logic [2:0] dst;
    logic       wen;
    logic       ld;
  } slot_t;

  typedef enum logic {IDLE, CTRL} state_t;

  state_t             state_q, state_d;
  logic [DRAIN_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  slot_t              ex_q, mem_q, wb_q, ex_d;
  logic               lu_haz;
  logic               go_ctrl;
  logic               unused_wb;

  // WB is kept for scoreboard completeness; nothing downstream consumes it yet.
  assign unused_wb = ^wb_q;

  always_comb begin
    lu_haz = valid_ID & ex_q.v & ex_q.wen & ex_q.ld &
             ((useR1_ID & (r1Num_ID == ex_q.dst)) |
              (useR2_ID & (r2Num_ID == ex_q.dst)));
  end

  // Next-state, drain counter and Mealy control outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    go_ctrl    = 1'b0;
    pcStall    = 1'b0;
    ifidStall  = 1'b0;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    case (state_q)
      IDLE: begin
        if (!memStall && valid_ID && ctrl_ID && !lu_haz) begin
          go_ctrl = 1'b1;
          state_d = CTRL;
          cnt_d   = DRAIN_W'(CTRL_DRAIN);
        end
      end
      CTRL: begin
        if (!memStall) begin
          cnt_d = cnt_q - DRAIN_W'(1);
          if (cnt_q == DRAIN_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst && !memStall) begin
      if (lu_haz) begin
        pcStall    = 1'b1;
        ifidStall  = 1'b1;
        idexBubble = 1'b1;
      end else if (state_q == CTRL || go_ctrl) begin
        pcStall   = 1'b1;
        ifidFlush = 1'b1;
      end
    end
  end

  // ID enters EX only when it is real, not held by a load-use, and not squashed.
  always_comb begin
    ex_d = '0;
    if (valid_ID && !lu_haz && state_q == IDLE) begin
      ex_d.v   = 1'b1;
      ex_d.dst = regWriteNum_ID;
      ex_d.wen = regWriteEnable_ID;
      ex_d.ld  = memRead_ID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
    end else if (!memStall) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= ex_d;
      if (pcStall && stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pipeFreeze = memStall;
  assign ctrlBusy   = !rst && (state_q == CTRL);
  assign stallCount = rst ? '0 : stall_cnt_q;

endmodule
